apb_master: RTL

- APB requester (bridge side) for the 8-bit-address / 8-bit-data APB peripheral bus.
- Accepts single read/write commands on a valid/ready command port, then drives the SETUP and ACCESS phases with PREADY wait states.
- Returns read data, or a timeout error, on a one-cycle response strobe.
- Sits between a local controller or CPU-side sequencer and one or more APB completers (PSELx fans out through external decode).

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_master_if.sv | 35 +++
 rtl/apb_master_timeout_ctr.sv | 33 +++
 rtl/apb_master.sv | 125 ++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths, requester state encoding, command record.
// Used by the requester, the existing completer and the testbench.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB bus signals of the requester, bundled as one port.
interface apb_master_if #(
  parameter int ADDR_W = apb_pkg::APB_ADDR_W,
  parameter int DATA_W = apb_pkg::APB_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;
  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_master_timeout_ctr.sv
// ACCESS-phase wait counter; expired flags the last permitted wait cycle.
// Saturates so a long stall can never wrap back into range.
module apb_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TC = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && (cnt_q != {CW{1'b1}}))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign expired = (TIMEOUT != 0) && (cnt_q == CW'(TC));

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time through SETUP/ACCESS, registered bus and response.
//   state  | meaning
//   IDLE   | cmd_ready high, bus idle; a valid command is latched onto the bus
//   SETUP  | PSELx high for one cycle, PENABLE rises next
//   ACCESS | wait for PREADY or the timeout, then strobe the response
module apb_master #(
  parameter int ADDR_W  = apb_pkg::APB_ADDR_W,
  parameter int DATA_W  = apb_pkg::APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input logic          PCLK,
  input logic          PRESETn,
  apb_master_if.master bus
);
  import apb_pkg::*;

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SETUP  = SETUP;
  localparam logic [1:0] ST_ACCESS = ACCESS;

  logic [1:0]        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              ctr_clear, ctr_en, ctr_expired;

  apb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clear   (ctr_clear),
    .enable  (ctr_en),
    .expired (ctr_expired)
  );

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    ctr_clear     = 1'b0;
    ctr_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          pwrite_d  = bus.cmd_write;
          paddr_d   = bus.cmd_addr;
          pwdata_d  = bus.cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        ctr_clear = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // PREADY is checked first so a completion on the limit edge still succeeds
        if (bus.PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          if (!pwrite_q) rsp_rdata_d = bus.PRDATA;
          state_d     = ST_IDLE;
        end else if (ctr_expired) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          state_d       = ST_IDLE;
        end else begin
          ctr_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= ST_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  assign bus.cmd_ready   = (state_q == ST_IDLE);
  assign bus.PSELx       = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.rsp_rdata   = rsp_rdata_q;

endmodule
